btn_pulse_gen: RTL and testbench

Two-channel input conditioner that turns raw, asynchronous, bouncing push-button signals A and B into clean, synchronous, single-cycle press pulses. It sits directly upstream of the A/B balance tracker (the fsm block with inA/inB inputs) and drives its inA/inB ports. It also exports debounced levels for LEDs and status logic.

---
 rtl/btn_pulse_pkg.sv | 14 +
 rtl/debounce_ch.sv | 99 +++++++++
 rtl/btn_pulse_gen.sv | 34 +++
 tb/tb_btn_pulse_gen.sv | 241 ++++++++++++++++++++++++
 4 files changed

// File: rtl/btn_pulse_pkg.sv
// Shared types and defaults for the push-button conditioner.
// Debounce state encoding plus the default stability window.
package btn_pulse_pkg;

    typedef enum logic [1:0] {
        IDLE,
        PRESS_WAIT,
        HELD,
        RELEASE_WAIT
    } deb_state_t;

    localparam int DEB_CYCLES_DEFAULT = 16;

endpackage

// File: rtl/debounce_ch.sv
// One button channel: 2-flop synchronizer, debounce FSM, registered pulse and level.
// Press/release accepted DEB_CYCLES+2 edges after raw changes; no backpressure, free-running.
module debounce_ch
    import btn_pulse_pkg::*;
#(
    parameter int DEB_CYCLES = DEB_CYCLES_DEFAULT
) (
    input  logic CLK,
    input  logic rst_n,
    input  logic i_raw,
    output logic o_pulse,
    output logic o_level
);

    localparam int              CNT_W = $clog2(DEB_CYCLES);
    localparam logic [CNT_W-1:0] LAST = CNT_W'(DEB_CYCLES - 1);

    if (DEB_CYCLES < 2 || DEB_CYCLES > 65535) begin : g_bad_deb_cycles
        $error("debounce_ch: DEB_CYCLES must be in 2..65535");
    end

    logic             r_sync1;
    logic             r_sync2;
    deb_state_t       r_state;
    deb_state_t       w_state_nxt;
    logic [CNT_W-1:0] r_cnt;
    logic [CNT_W-1:0] w_cnt_nxt;
    logic             w_pulse_nxt;
    logic             w_level_nxt;
    logic             r_pulse;
    logic             r_level;

    always_ff @(posedge CLK or negedge rst_n) begin
        if (!rst_n) begin
            r_sync1 <= 1'b0;
            r_sync2 <= 1'b0;
            r_state <= IDLE;
            r_cnt   <= '0;
            r_pulse <= 1'b0;
            r_level <= 1'b0;
        end else begin
            r_sync1 <= i_raw;
            r_sync2 <= r_sync1;
            r_state <= w_state_nxt;
            r_cnt   <= w_cnt_nxt;
            r_pulse <= w_pulse_nxt;
            r_level <= w_level_nxt;
        end
    end

    // Counter is compared before incrementing, so it tops out at LAST and never wraps.
    always_comb begin
        w_state_nxt = r_state;
        w_cnt_nxt   = r_cnt;
        w_pulse_nxt = 1'b0;
        case (r_state)
            IDLE: begin
                if (r_sync2) begin
                    w_state_nxt = PRESS_WAIT;
                    w_cnt_nxt   = '0;
                end
            end
            PRESS_WAIT: begin
                if (!r_sync2) begin
                    w_state_nxt = IDLE;
                end else if (r_cnt == LAST) begin
                    w_state_nxt = HELD;
                    w_pulse_nxt = 1'b1;
                end else begin
                    w_cnt_nxt = r_cnt + 1'b1;
                end
            end
            HELD: begin
                if (!r_sync2) begin
                    w_state_nxt = RELEASE_WAIT;
                    w_cnt_nxt   = '0;
                end
            end
            RELEASE_WAIT: begin
                if (r_sync2) begin
                    w_state_nxt = HELD;
                end else if (r_cnt == LAST) begin
                    w_state_nxt = IDLE;
                end else begin
                    w_cnt_nxt = r_cnt + 1'b1;
                end
            end
            default: begin
                w_state_nxt = IDLE;
                w_cnt_nxt   = '0;
            end
        endcase
        w_level_nxt = (w_state_nxt == HELD) || (w_state_nxt == RELEASE_WAIT);
    end

    assign o_pulse = r_pulse;
    assign o_level = r_level;

endmodule

// File: rtl/btn_pulse_gen.sv
// Two independent debounced button channels producing press pulses and levels.
// Output latency DEB_CYCLES+2 edges from a raw change; no backpressure, outputs are registered.
module btn_pulse_gen
    import btn_pulse_pkg::*;
#(
    parameter int DEB_CYCLES = DEB_CYCLES_DEFAULT
) (
    input  logic CLK,
    input  logic rst_n,
    input  logic btnA_raw,
    input  logic btnB_raw,
    output logic pulseA,
    output logic pulseB,
    output logic levelA,
    output logic levelB
);

    debounce_ch #(.DEB_CYCLES(DEB_CYCLES)) u_ch_a (
        .CLK     (CLK),
        .rst_n   (rst_n),
        .i_raw   (btnA_raw),
        .o_pulse (pulseA),
        .o_level (levelA)
    );

    debounce_ch #(.DEB_CYCLES(DEB_CYCLES)) u_ch_b (
        .CLK     (CLK),
        .rst_n   (rst_n),
        .i_raw   (btnB_raw),
        .o_pulse (pulseB),
        .o_level (levelB)
    );

endmodule

// File: tb/tb_btn_pulse_gen.sv
// Bench for btn_pulse_gen with DEB_CYCLES=4: directed corner sequences, a segment table,
// and random stimulus checked every cycle against a run-length reference model.
module tb_btn_pulse_gen;

    localparam int D = 4;

    logic CLK = 1'b0;
    logic rst_n = 1'b0;
    logic btnA_raw = 1'b0;
    logic btnB_raw = 1'b0;
    logic pulseA, pulseB, levelA, levelB;

    btn_pulse_gen #(.DEB_CYCLES(D)) dut (
        .CLK      (CLK),
        .rst_n    (rst_n),
        .btnA_raw (btnA_raw),
        .btnB_raw (btnB_raw),
        .pulseA   (pulseA),
        .pulseB   (pulseB),
        .levelA   (levelA),
        .levelB   (levelB)
    );

    always #5 CLK = ~CLK;

    int n_cmp = 0;
    int n_bad = 0;
    int cnt_a = 0;
    int cnt_b = 0;

    // Reference: a level flips once the synchronized input has disagreed with it
    // on D+1 consecutive edges; a flip to 1 is a press pulse.
    logic m_p1  [2];
    logic m_p2  [2];
    logic m_lvl [2];
    logic m_pul [2];
    int   m_run [2];

    typedef struct {
        logic a;
        logic b;
        int   n;
        int   pa;
        int   pb;
        logic la;
        logic lb;
    } vec_t;
    vec_t tbl [10];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        for (int c = 0; c < 2; c++) begin
            m_p1[c] = 1'b0; m_p2[c] = 1'b0; m_lvl[c] = 1'b0;
            m_pul[c] = 1'b0; m_run[c] = 0;
        end
    endtask

    task automatic model_step(input logic a, input logic b);
        logic raw [2];
        logic s;
        raw[0] = a; raw[1] = b;
        for (int c = 0; c < 2; c++) begin
            s = m_p2[c];
            m_pul[c] = 1'b0;
            if (s != m_lvl[c]) begin
                m_run[c]++;
                if (m_run[c] == D + 1) begin
                    m_lvl[c] = s;
                    m_pul[c] = s;
                    m_run[c] = 0;
                end
            end else begin
                m_run[c] = 0;
            end
            m_p2[c] = m_p1[c];
            m_p1[c] = raw[c];
        end
    endtask

    task automatic tick(input logic a, input logic b, input logic r);
        @(negedge CLK);
        btnA_raw = a;
        btnB_raw = b;
        if (!r) begin
            if (rst_n) begin
                rst_n = 1'b0;
                model_reset();
                #1;
                chk("rst_immediate", {28'd0, pulseA, pulseB, levelA, levelB}, 32'd0);
            end
        end else begin
            rst_n = 1'b1;
        end
        @(posedge CLK);
        if (rst_n) model_step(a, b);
        else model_reset();
        #1;
        chk("cycle_model", {28'd0, pulseA, pulseB, levelA, levelB},
            {28'd0, m_pul[0], m_pul[1], m_lvl[0], m_lvl[1]});
        cnt_a += int'(pulseA);
        cnt_b += int'(pulseB);
    endtask

    task automatic release_all();
        for (int i = 0; i < 12; i++) tick(1'b0, 1'b0, 1'b1);
    endtask

    initial begin
        int pe, pe_b, fe, l5, l6, lmin, quiet;
        int ha, hb, rst_left;
        logic va, vb;

        tbl[0] = '{a:1'b0, b:1'b0, n:6,  pa:0, pb:0, la:1'b0, lb:1'b0};
        tbl[1] = '{a:1'b1, b:1'b0, n:4,  pa:0, pb:0, la:1'b0, lb:1'b0};
        tbl[2] = '{a:1'b0, b:1'b0, n:12, pa:0, pb:0, la:1'b0, lb:1'b0};
        tbl[3] = '{a:1'b1, b:1'b0, n:5,  pa:0, pb:0, la:1'b0, lb:1'b0};
        tbl[4] = '{a:1'b0, b:1'b0, n:12, pa:1, pb:0, la:1'b0, lb:1'b0};
        tbl[5] = '{a:1'b0, b:1'b1, n:12, pa:0, pb:1, la:1'b0, lb:1'b1};
        tbl[6] = '{a:1'b1, b:1'b1, n:12, pa:1, pb:0, la:1'b1, lb:1'b1};
        tbl[7] = '{a:1'b1, b:1'b0, n:3,  pa:0, pb:0, la:1'b1, lb:1'b1};
        tbl[8] = '{a:1'b1, b:1'b1, n:12, pa:0, pb:0, la:1'b1, lb:1'b1};
        tbl[9] = '{a:1'b0, b:1'b0, n:12, pa:0, pb:0, la:1'b0, lb:1'b0};

        model_reset();
        #1;
        chk("reset_state", {28'd0, pulseA, pulseB, levelA, levelB}, 32'd0);
        for (int i = 0; i < 3; i++) tick(1'b0, 1'b0, 1'b0);
        for (int i = 0; i < 4; i++) tick(1'b0, 1'b0, 1'b1);

        // Clean press on A
        cnt_a = 0; pe = -1; l5 = -1; l6 = -1; quiet = 0;
        for (int i = 0; i < 10; i++) begin
            tick(1'b1, 1'b0, 1'b1);
            if (pulseA && pe < 0) pe = i;
            if (i == 5) l5 = int'(levelA);
            if (i == 6) l6 = int'(levelA);
            quiet += int'(pulseB | levelB);
        end
        chk("press_pulse_edge", pe, 6);
        chk("press_pulse_count", cnt_a, 1);
        chk("press_level_before", l5, 0);
        chk("press_level_at_edge6", l6, 1);
        chk("press_b_quiet", quiet, 0);

        // Short release glitch while held
        cnt_a = 0; lmin = 1;
        for (int i = 0; i < 3; i++) begin
            tick(1'b0, 1'b0, 1'b1);
            if (!levelA) lmin = 0;
        end
        for (int i = 0; i < 10; i++) begin
            tick(1'b1, 1'b0, 1'b1);
            if (!levelA) lmin = 0;
        end
        chk("glitch_level_held", lmin, 1);
        chk("glitch_no_repulse", cnt_a, 0);

        fe = -1;
        for (int i = 0; i < 12; i++) begin
            tick(1'b0, 1'b0, 1'b1);
            if (!levelA && fe < 0) fe = i;
        end
        chk("release_level_edge", fe, 6);

        // Bounce: 1,1,0,0,1,1,0,0 then steady high from index 8
        cnt_a = 0; pe = -1;
        for (int i = 0; i < 20; i++) begin
            tick((i >= 8) ? 1'b1 : ((i % 4) < 2), 1'b0, 1'b1);
            if (pulseA && pe < 0) pe = i;
        end
        chk("bounce_pulse_edge", pe, 14);
        chk("bounce_pulse_count", cnt_a, 1);
        release_all();

        // Simultaneous press
        cnt_a = 0; cnt_b = 0; pe = -1; pe_b = -1;
        for (int i = 0; i < 10; i++) begin
            tick(1'b1, 1'b1, 1'b1);
            if (pulseA && pe < 0) pe = i;
            if (pulseB && pe_b < 0) pe_b = i;
        end
        chk("simul_pulse_a_edge", pe, 6);
        chk("simul_pulse_b_edge", pe_b, 6);
        chk("simul_counts", {cnt_a[15:0], cnt_b[15:0]}, {16'd1, 16'd1});
        release_all();

        // Reset while A is mid-debounce (PRESS_WAIT, cnt=2), then long hold
        cnt_a = 0;
        for (int i = 0; i < 5; i++) tick(1'b1, 1'b0, 1'b1);
        chk("middeb_no_pulse_yet", cnt_a, 0);
        quiet = 0;
        for (int i = 0; i < 3; i++) begin
            tick(1'b1, 1'b0, 1'b0);
            quiet += int'(pulseA | pulseB | levelA | levelB);
        end
        chk("middeb_outputs_in_reset", quiet, 0);
        cnt_a = 0; pe = -1; lmin = 1;
        for (int i = 0; i < 1006; i++) begin
            tick(1'b1, 1'b0, 1'b1);
            if (pulseA && pe < 0) pe = i;
            if (i >= 6 && !levelA) lmin = 0;
        end
        chk("postrst_pulse_edge", pe, 6);
        chk("longhold_pulse_count", cnt_a, 1);
        chk("longhold_level", lmin, 1);
        release_all();

        // Segment table
        for (int v = 0; v < 10; v++) begin
            cnt_a = 0; cnt_b = 0;
            for (int i = 0; i < tbl[v].n; i++) tick(tbl[v].a, tbl[v].b, 1'b1);
            chk($sformatf("tbl%0d_pulses_a", v), cnt_a, tbl[v].pa);
            chk($sformatf("tbl%0d_pulses_b", v), cnt_b, tbl[v].pb);
            chk($sformatf("tbl%0d_level_a", v), {31'd0, levelA}, {31'd0, tbl[v].la});
            chk($sformatf("tbl%0d_level_b", v), {31'd0, levelB}, {31'd0, tbl[v].lb});
        end

        // Random stimulus against the reference model
        ha = 0; hb = 0; va = 1'b0; vb = 1'b0; rst_left = 0;
        for (int i = 0; i < 3000; i++) begin
            if (ha == 0) begin va = $urandom_range(0, 1) != 0; ha = $urandom_range(1, 12); end
            if (hb == 0) begin vb = $urandom_range(0, 1) != 0; hb = $urandom_range(1, 12); end
            if (rst_left == 0 && $urandom_range(0, 399) == 0) rst_left = 2;
            tick(va, vb, rst_left == 0);
            ha--; hb--;
            if (rst_left > 0) rst_left--;
        end
        tick(1'b0, 1'b0, 1'b1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
